pipe_add_unit: RTL

//  Parametrised registered add/subtract/accumulate unit; successor to the fixed 16-bit operand/result register adder.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/chunk_adder.sv | 18 +
 rtl/pipe_add_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered add/subtract/accumulate unit.
// The op encoding is also used by the decode logic that drives pipe_add_unit.op.
package alu_pkg;

    // Operation select. OP_RSV is decoded as an ordinary add.
    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_ACC = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    // Control FSM: waiting for start, or rippling chunks of an accepted op.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    // Two's-complement overflow: the operands share a sign that the sum does not.
    function automatic logic signed_overflow(input logic x_msb,
                                             input logic y_msb,
                                             input logic sum_msb);
        return (x_msb == y_msb) && (sum_msb != x_msb);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// One slice of the carry chain: a plain W-bit adder with carry in and out.
// The top time-multiplexes a single instance across all chunks of the word.
module chunk_adder #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);

    // Widen by one bit so the carry out falls out of the same addition.
    always_comb begin
        {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
    end

endmodule

// File: rtl/pipe_add_unit.sv
// Registered add/subtract/accumulate unit with a start/busy/done handshake.
// An accepted operation is snapshotted and then summed CHUNK bits per cycle,
// LSB first, so the critical path is one chunk wide regardless of WIDTH.
// result/cout/ovf only change at the commit edge and never expose partial sums.
module pipe_add_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_a,
    input  logic [WIDTH-1:0] d_b,
    input  logic             en_a,
    input  logic             en_b,
    input  logic             cin,
    input  logic [1:0]       op,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int CNT_W  = (STAGES > 1) ? $clog2(STAGES) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(STAGES - 1);

    // Programmer-visible operand registers.
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    // Snapshot of the accepted operation and its running state.
    logic [WIDTH-1:0] op_x;
    logic [WIDTH-1:0] op_y;
    logic [WIDTH-1:0] part_sum;
    logic             run_carry;
    logic [CNT_W-1:0] cnt;
    state_e           state;

    // Operand choice for a new operation, decoded from op.
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic             sel_c;

    // Current chunk slice and the word with that chunk filled in.
    int unsigned      slice_lo;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_co;
    logic [WIDTH-1:0] sum_next;
    logic             last_chunk;

    assign busy       = (state == S_RUN);
    assign last_chunk = (cnt == LAST_CHUNK);

    // Operand registers load whenever enabled; an in-flight op has its own copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (en_a) begin
                a_reg <= d_a;
            end
            if (en_b) begin
                b_reg <= d_b;
            end
        end
    end

    // Map op onto X + Y + c0: subtract is A + ~B + 1, accumulate feeds result back.
    always_comb begin
        sel_x = a_reg;
        sel_y = b_reg;
        sel_c = cin;
        case (op_e'(op))
            OP_SUB: begin
                sel_y = ~b_reg;
                sel_c = 1'b1;
            end
            OP_ACC: begin
                sel_x = result;
                sel_y = a_reg;
            end
            default: begin
            end
        endcase
    end

    // Pick the counter-selected chunk out of the snapshot and merge its sum back in.
    always_comb begin
        slice_lo = 32'(cnt) * 32'(CHUNK);
        chunk_a  = CHUNK'(op_x >> slice_lo);
        chunk_b  = CHUNK'(op_y >> slice_lo);
        sum_next = part_sum | (WIDTH'(chunk_sum) << slice_lo);
    end

    chunk_adder #(
        .W(CHUNK)
    ) u_chunk_adder (
        .a  (chunk_a),
        .b  (chunk_b),
        .ci (run_carry),
        .sum(chunk_sum),
        .co (chunk_co)
    );

    // Control FSM plus snapshot, per-chunk accumulation and the commit of results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_x      <= '0;
            op_y      <= '0;
            part_sum  <= '0;
            run_carry <= 1'b0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_x      <= sel_x;
                        op_y      <= sel_y;
                        run_carry <= sel_c;
                        part_sum  <= '0;
                        cnt       <= '0;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (last_chunk) begin
                        result <= sum_next;
                        cout   <= chunk_co;
                        ovf    <= signed_overflow(op_x[WIDTH-1], op_y[WIDTH-1],
                                                  sum_next[WIDTH-1]);
                        done   <= 1'b1;
                        cnt    <= '0;
                        state  <= S_IDLE;
                    end else begin
                        part_sum  <= sum_next;
                        run_carry <= chunk_co;
                        cnt       <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
